fibo_result_fifo: RTL
=====================

Name: fibo_result_fifo

Overview:
- Downstream consumer of the Fibonacci generator. Captures each Fibo_out word qualified by Fibo_valid into a small FIFO.
- Presents buffered results to a sink over a valid/ready handshake, so a slow consumer never loses results.
- Reports occupancy and counts dropped results when the buffer is full.

Parameters:
- DATA_W, 16, width of each result word; matches the generator output bus.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- ADDR_W, 3, log2(DEPTH).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Fibo_valid  input  1  one-cycle qualifier; Fibo_out is valid this cycle.
- Fibo_out  input  DATA_W  result word from the generator.
- out_valid  output  1  head entry is available.
- out_data  output  DATA_W  head entry; forced to 0 when empty.
- out_ready  input  1  sink accepts the head entry this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: at least one result was dropped.
- drop_cnt  output  DROP_W  number of dropped results; saturates at all-ones.
- ovf_clr  input  1  clears overflow and drop_cnt.

Behaviour:
- Clocking and reset:
  - One clock domain. reset is synchronous, active-high, and sampled on the rising edge of clk.
  - On reset: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries on that edge. Any push, pop or clear in the same cycle is ignored.
- Storage and pointers:
  - Register array of DEPTH x DATA_W.
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the low ADDR_W bits index the array; both wrap naturally modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) and (MSBs differ).
- Output side:
  - First-word-fall-through. out_valid = ~empty.
  - out_data = mem[rd_ptr] when not empty, else 0 (combinational read of registered storage).
- Push and pop conditions:
  - pop = out_valid & out_ready. On a pop, rd_ptr increments at the edge.
  - push_req = Fibo_valid.
  - push is accepted when (~full) | pop. A push while full is accepted only if a pop happens in the same cycle.
  - An accepted push writes Fibo_out to mem[wr_ptr] and increments wr_ptr.
- Latency:
  - A word pushed at edge t appears on out_data with out_valid=1 in the cycle after edge t.
  - An empty FIFO has no bypass path to the output.
- Simultaneous push and pop:
  - count is unchanged.
  - When empty, pop is impossible (out_valid=0), so only the push takes effect.
- Drop on full:
  - Condition: Fibo_valid & full & ~pop. The word is discarded and no pointers move.
  - overflow is set to 1.
  - drop_cnt increments by 1 and saturates at 2^DROP_W-1, never wrapping.
- ovf_clr:
  - Clears overflow and drop_cnt at the edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- Protocol rule: out_ready while out_valid=0 has no effect.
- No combinational path from Fibo_valid or Fibo_out to any output. Only out_data, out_valid and flags that derive from pointers or registers.

Test Plan:
- Reset:
  - Stimulus: reset high for 2 cycles, then low with no traffic.
  - Required: out_valid=0, empty=1, full=0, count=0, out_data=0, overflow=0, drop_cnt=0.
- Ordered pass-through:
  - Stimulus: push 0,1,1,2,3,5,8,13 on consecutive cycles with out_ready=0.
  - Required: full=1 and count=8 after the 8th edge. Then raise out_ready=1; the sink receives 0,1,1,2,3,5,8,13 in order, one per cycle; empty=1 after the 8th pop.
- Drop and saturation:
  - Stimulus: with the FIFO full and out_ready=0, push 21 then 34.
  - Required: both dropped; overflow=1, drop_cnt=2; head is still 0.
  - Stimulus: continue with 300 further drops.
  - Required: drop_cnt saturates at 255.
- Full with simultaneous push and pop:
  - Stimulus: with the FIFO full holding 0..13, assert Fibo_valid=1 with value 21 and out_ready=1 in the same cycle.
  - Required: 0 popped, 21 accepted, count stays 8, no drop; the final drain order ends ...,13,21.
- Clear priority:
  - Stimulus: ovf_clr=1 alone.
  - Required: overflow=0, drop_cnt=0.
  - Stimulus: ovf_clr=1 coincident with a drop.
  - Required: overflow=1, drop_cnt=1.
- Wrap-around and reset mid-operation:
  - Stimulus: stream 20 words with out_ready toggling 1,0,1,0 each cycle.
  - Required: every word is delivered in order, nothing is dropped, and pointers wrap correctly past 2*DEPTH.
  - Stimulus: assert reset while count=5.
  - Required: the next cycle shows empty=1, count=0, out_valid=0.

Source files
------------

// File: rtl/fibo_result_fifo.sv
// Result buffer behind the Fibonacci generator: FWFT FIFO with a valid/ready sink,
// occupancy flags and a sticky, saturating drop counter for pushes lost while full.
module fibo_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Fibo_valid,
  input  logic [DATA_W-1:0] Fibo_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              ovf_clr
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              pop, push, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // A pop frees the slot the same cycle, so a full FIFO can still take a push.
  assign pop  = out_valid & out_ready;
  assign push = Fibo_valid & (~full | pop);
  assign drop = Fibo_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr[ADDR_W-1:0]] <= Fibo_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)            drop_cnt <= {{(DROP_W-1){1'b0}}, 1'b1};
      else if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
